// File: rtl/vga_640x480_sync.sv
// -----------------------------------------------------------------------------
// vga_640x480_sync
//
// Timing generator for a 640x480 @ 60 Hz VGA output. The board clock is
// divided by DIV into a one-cycle pixel enable. That enable advances a
// horizontal pixel counter and a vertical line counter. Sync, blanking and
// the line/frame markers are decoded combinationally from the registered
// counters, so they always agree with the hc/vc presented in the same cycle.
//
// Parameters
//   DIV      board clocks per pixel (must be >= 2)
//   HPIXELS  pixel clocks per line          VLINES  lines per frame
//   HSP      hsync pulse width (pixels)     VSP     vsync pulse width (lines)
//   HBP      first visible hc               HFP     first hidden hc after active
//   VBP      first visible vc               VFP     first hidden vc after active
//
// Ports
//   clk          in   board clock, the only clock
//   clr          in   synchronous active-high reset
//   pix_en       out  one-clk pulse every DIV clocks; qualifies counter steps
//   hc           out  horizontal count, 0..HPIXELS-1
//   vc           out  vertical count, 0..VLINES-1
//   hsync        out  active-low horizontal sync
//   vsync        out  active-low vertical sync
//   vidon        out  high inside the visible region
//   line_end     out  pix_en & (hc == HPIXELS-1)
//   frame_start  out  pix_en & (hc == 0) & (vc == 0)
// -----------------------------------------------------------------------------
module vga_640x480_sync #(
  parameter int DIV     = 4,
  parameter int HPIXELS = 800,
  parameter int VLINES  = 521,
  parameter int HSP     = 96,
  parameter int VSP     = 2,
  parameter int HBP     = 144,
  parameter int HFP     = 784,
  parameter int VBP     = 31,
  parameter int VFP     = 511
) (
  input  logic       clk,
  input  logic       clr,
  output logic       pix_en,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       hsync,
  output logic       vsync,
  output logic       vidon,
  output logic       line_end,
  output logic       frame_start
);

  // Divider width: DIV=2 still needs one bit.
  localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_PRE  = DW'(DIV - 2);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);

  localparam logic [9:0] H_LAST = 10'(HPIXELS - 1);
  localparam logic [9:0] V_LAST = 10'(VLINES - 1);
  localparam logic [9:0] HSP_C  = 10'(HSP);
  localparam logic [9:0] VSP_C  = 10'(VSP);
  localparam logic [9:0] HBP_C  = 10'(HBP);
  localparam logic [9:0] HFP_C  = 10'(HFP);
  localparam logic [9:0] VBP_C  = 10'(VBP);
  localparam logic [9:0] VFP_C  = 10'(VFP);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          pix_en_q,  pix_en_d;
  logic [9:0]    hc_q,      hc_d;
  logic [9:0]    vc_q,      vc_d;

  // Next-state logic. pix_en is registered from div_cnt == DIV-2 so that it
  // is high exactly while div_cnt == DIV-1, without a compare on the output.
  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_ONE;
    pix_en_d  = (div_cnt_q == DIV_PRE);
    hc_d      = hc_q;
    vc_d      = vc_q;
    if (pix_en_q) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        // The line counter only moves on the edge where hc wraps.
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
      end else begin
        hc_d = hc_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      div_cnt_q <= '0;
      pix_en_q  <= 1'b0;
      hc_q      <= '0;
      vc_q      <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pix_en_q  <= pix_en_d;
      hc_q      <= hc_d;
      vc_q      <= vc_d;
    end
  end

  // Decode straight from the registered counters: zero extra latency, so the
  // renderer sees sync/blanking consistent with the coordinates it receives.
  assign pix_en      = pix_en_q;
  assign hc          = hc_q;
  assign vc          = vc_q;
  assign hsync       = (hc_q >= HSP_C);
  assign vsync       = (vc_q >= VSP_C);
  assign vidon       = (hc_q >= HBP_C) && (hc_q < HFP_C) &&
                       (vc_q >= VBP_C) && (vc_q < VFP_C);
  assign line_end    = pix_en_q && (hc_q == H_LAST);
  assign frame_start = pix_en_q && (hc_q == 10'd0) && (vc_q == 10'd0);

endmodule

// File: tb/tb_vga_640x480_sync.sv
// Bench for vga_640x480_sync. Two instances share clk/clr:
//   full  - default 640x480 timing, used for reset timing and the line wrap
//   small - shrunken geometry (20x12 pixels per frame, DIV=4) so whole frames
//           fit in a short run; its expected values are worked out by hand
//           below for HSP=3, VSP=2, HBP=5, HFP=17, VBP=3, VFP=10.
//   small line = 80 clk, frame = 960 clk, visible = 12 x 7 = 84 pixels.
module tb_vga_640x480_sync;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       f_pix_en, f_hsync, f_vsync, f_vidon, f_line_end, f_frame_start;
  logic [9:0] f_hc, f_vc;
  logic       s_pix_en, s_hsync, s_vsync, s_vidon, s_line_end, s_frame_start;
  logic [9:0] s_hc, s_vc;

  vga_640x480_sync dut_full (
    .clk(clk), .clr(clr), .pix_en(f_pix_en), .hc(f_hc), .vc(f_vc),
    .hsync(f_hsync), .vsync(f_vsync), .vidon(f_vidon),
    .line_end(f_line_end), .frame_start(f_frame_start)
  );

  vga_640x480_sync #(
    .DIV(4), .HPIXELS(20), .VLINES(12), .HSP(3), .VSP(2),
    .HBP(5), .HFP(17), .VBP(3), .VFP(10)
  ) dut_small (
    .clk(clk), .clr(clr), .pix_en(s_pix_en), .hc(s_hc), .vc(s_vc),
    .hsync(s_hsync), .vsync(s_vsync), .vidon(s_vidon),
    .line_end(s_line_end), .frame_start(s_frame_start)
  );

  // Advance one clock and sample 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run the small instance until a pix_en cycle at (h,v); bounded.
  task automatic wait_small(input int h, input int v, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (s_pix_en && s_hc == 10'(h) && s_vc == 10'(v)) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_small(%0d,%0d) timed out: at hc=%0d vc=%0d", h, v, s_hc, s_vc);
    end
  endtask

  task automatic test_reset();
    int cy;
    clr = 1'b1;
    repeat (5) step();
    checks++;
    if ({f_hc, f_vc} !== 20'd0) begin
      errors++; $display("FAIL reset_counters got hc=%0d vc=%0d want 0 0", f_hc, f_vc);
    end
    checks++;
    if ({f_pix_en, f_hsync, f_vsync, f_vidon} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got pe/hs/vs/vid=%b want 0000",
                         {f_pix_en, f_hsync, f_vsync, f_vidon});
    end
    checks++;
    if ({s_line_end, s_frame_start, f_line_end, f_frame_start} !== 4'b0000) begin
      errors++; $display("FAIL reset_markers got %b want 0000",
                         {s_line_end, s_frame_start, f_line_end, f_frame_start});
    end
    // Release: the next edge is cycle 0. After edge k we see cycle k+1.
    clr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      cy = k + 1;
      checks++;
      if (f_pix_en !== (cy == 3)) begin
        errors++; $display("FAIL post_reset_pix_en cycle %0d got %b want %b", cy, f_pix_en, (cy == 3));
      end
      checks++;
      if (f_hc !== ((cy >= 4) ? 10'd1 : 10'd0)) begin
        errors++; $display("FAIL post_reset_hc cycle %0d got %0d want %0d", cy, f_hc, (cy >= 4) ? 1 : 0);
      end
    end
  endtask

  task automatic test_full_hwrap();
    int hs_bad = 0, vid_bad = 0, n_pe = 0;
    bit ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (f_pix_en) begin
        n_pe++;
        if (f_hsync !== (f_hc >= 10'd96)) hs_bad++;
        if (f_vidon !== 1'b0) vid_bad++;
        if (f_hc == 10'd799 && f_vc == 10'd0) begin ok = 1'b1; break; end
      end
      step();
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL full_reach_799 timed out at hc=%0d vc=%0d", f_hc, f_vc); end
    checks++;
    if (hs_bad !== 0 || n_pe < 790) begin
      errors++; $display("FAIL full_hsync_decode bad=%0d of %0d want 0 bad", hs_bad, n_pe);
    end
    checks++;
    if (vid_bad !== 0) begin errors++; $display("FAIL full_vidon_line0 got %0d high want 0", vid_bad); end
    checks++;
    if (f_line_end !== 1'b1) begin errors++; $display("FAIL full_line_end got %b want 1", f_line_end); end
    step();
    checks++;
    if (f_hc !== 10'd0 || f_vc !== 10'd1) begin
      errors++; $display("FAIL full_hwrap got hc=%0d vc=%0d want 0 1", f_hc, f_vc);
    end
    checks++;
    if (f_line_end !== 1'b0 || f_hsync !== 1'b0) begin
      errors++; $display("FAIL full_after_wrap le/hs got %b%b want 00", f_line_end, f_hsync);
    end
  endtask

  task automatic test_small_hwrap();
    wait_small(19, 4, 2000);
    checks++;
    if (s_line_end !== 1'b1) begin errors++; $display("FAIL small_line_end got %b want 1", s_line_end); end
    step();
    checks++;
    if (s_hc !== 10'd0 || s_vc !== 10'd5) begin
      errors++; $display("FAIL small_hwrap got hc=%0d vc=%0d want 0 5", s_hc, s_vc);
    end
    checks++;
    if (s_line_end !== 1'b0) begin errors++; $display("FAIL small_line_end_drop got %b want 0", s_line_end); end
  endtask

  task automatic test_vwrap();
    wait_small(19, 11, 2000);
    step();
    checks++;
    if (s_hc !== 10'd0 || s_vc !== 10'd0) begin
      errors++; $display("FAIL vwrap got hc=%0d vc=%0d want 0 0", s_hc, s_vc);
    end
    checks++;
    if (s_frame_start !== 1'b0 || s_vsync !== 1'b0) begin
      errors++; $display("FAIL vwrap_nopulse fs/vs got %b%b want 00", s_frame_start, s_vsync);
    end
    repeat (3) step();
    checks++;
    if (s_pix_en !== 1'b1 || s_frame_start !== 1'b1) begin
      errors++; $display("FAIL frame_start_pulse pe/fs got %b%b want 11", s_pix_en, s_frame_start);
    end
    step();
    checks++;
    if (s_frame_start !== 1'b0) begin errors++; $display("FAIL frame_start_width got %b want 0", s_frame_start); end
  endtask

  task automatic test_visible();
    int  ph [6] = '{4, 5, 16, 17, 5, 5};
    int  pv [6] = '{3, 3, 9, 9, 2, 10};
    bit  pe [6] = '{0, 1, 1, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      wait_small(ph[i], pv[i], 2000);
      checks++;
      if (s_vidon !== pe[i]) begin
        errors++; $display("FAIL vidon_point (%0d,%0d) got %b want %b", ph[i], pv[i], s_vidon, pe[i]);
      end
    end
  endtask

  task automatic test_frame_scan();
    int  t0 = 0, t1 = 0, vid_cnt = 0, vs_bad = 0, n_fall = 0, gap_bad = 0, last_fall = -1;
    bit  prev_hs, got0 = 1'b0, got1 = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (s_frame_start) begin got0 = 1'b1; break; end
      step();
    end
    t0 = cyc;
    prev_hs = s_hsync;
    for (int i = 0; i < 1200 && got0; i++) begin
      step();
      if (prev_hs && !s_hsync) begin
        if (last_fall >= 0 && (cyc - last_fall) != 80) gap_bad++;
        last_fall = cyc;
        n_fall++;
      end
      prev_hs = s_hsync;
      if (s_frame_start) begin t1 = cyc; got1 = 1'b1; break; end
      if (s_pix_en) begin
        if (s_vidon) vid_cnt++;
        if (s_vsync !== (s_vc >= 10'd2)) vs_bad++;
      end
    end
    checks++;
    if (!(got0 && got1) || (t1 - t0) != 960) begin
      errors++; $display("FAIL frame_period got %0d clk want 960", t1 - t0);
    end
    checks++;
    if (vid_cnt != 84) begin errors++; $display("FAIL vidon_count got %0d want 84", vid_cnt); end
    checks++;
    if (vs_bad != 0) begin errors++; $display("FAIL vsync_decode bad=%0d want 0", vs_bad); end
    checks++;
    if (n_fall != 12 || gap_bad != 0) begin
      errors++; $display("FAIL hsync_fall_spacing falls=%0d bad_gaps=%0d want 12 0", n_fall, gap_bad);
    end
  endtask

  task automatic test_mid_reset();
    int cy;
    wait_small(9, 6, 2000);
    repeat (3) step();   // now hc=10, vc=6, divider at DIV-2
    checks++;
    if (s_hc !== 10'd10 || s_pix_en !== 1'b0) begin
      errors++; $display("FAIL mid_reset_setup got hc=%0d pe=%b want 10 0", s_hc, s_pix_en);
    end
    clr = 1'b1;
    step();
    checks++;
    if (s_hc !== 10'd0 || s_vc !== 10'd0 || s_pix_en !== 1'b0) begin
      errors++; $display("FAIL mid_reset got hc=%0d vc=%0d pe=%b want 0 0 0", s_hc, s_vc, s_pix_en);
    end
    clr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      cy = k + 1;
      checks++;
      if (s_pix_en !== (cy == 3) || s_frame_start !== (cy == 3)) begin
        errors++; $display("FAIL mid_reset_pix_en cycle %0d got pe=%b fs=%b want %b", cy, s_pix_en, s_frame_start, (cy == 3));
      end
      checks++;
      if (s_hc !== ((cy >= 4) ? 10'd1 : 10'd0) || s_vc !== 10'd0) begin
        errors++; $display("FAIL mid_reset_hc cycle %0d got hc=%0d vc=%0d want %0d 0", cy, s_hc, s_vc, (cy >= 4) ? 1 : 0);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_full_hwrap();
    test_small_hwrap();
    test_vwrap();
    test_visible();
    test_frame_scan();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
